csa_accumulator: RTL and testbench

Sequential multi-operand accumulator that sits directly downstream of the 16-bit 3:2 carry-save adder stage. It takes a stream of 16-bit operands over a valid/ready handshake and keeps the running total in redundant sum/carry form, so each accumulate step is a single 3:2 compression with no carry propagation. When the packet's last operand arrives, it resolves the sum/carry pair into a binary result with a chunked carry-propagate adder over several cycles. It then presents the result on an output handshake.

---
 rtl/csa_acc_if.sv | 24 ++
 rtl/csa_accumulator.sv | 114 +++++++++++
 tb/tb_csa_accumulator.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/csa_acc_if.sv
// Operand/result handshake bundle for csa_accumulator.
// master = upstream producer / result consumer, slave = the accumulator.
interface csa_acc_if #(
  parameter int ACC_W = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [7:0]       out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/csa_accumulator.sv
// Carry-save multi-operand accumulator with a chunked carry-propagate resolve phase.
// Optional sticky overflow flag built when CSA_ACC_OVF_EN is defined.
module csa_accumulator #(
  parameter int ACC_W = 20,
  parameter int CHUNK = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  csa_acc_if.slave  bus
);
  localparam int NCH   = ACC_W / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {ACC, RES, OUT} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   sum_q, sum_d, carry_q, carry_d, res_q, res_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               cin_q, cin_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [ACC_W-1:0]   op;
  logic [ACC_W-2:0]   maj;
  logic [CHUNK:0]     chunk;
  logic               deliver;

  assign op = {{(ACC_W-16){1'b0}}, bus.in_data};
  // Top majority bit is shifted out of carry_q; only the overflow logic looks at it.
  assign maj = (sum_q[ACC_W-2:0] & carry_q[ACC_W-2:0]) |
               (sum_q[ACC_W-2:0] & op[ACC_W-2:0]) |
               (carry_q[ACC_W-2:0] & op[ACC_W-2:0]);
  assign chunk = {1'b0, sum_q[idx_q*CHUNK +: CHUNK]} +
                 {1'b0, carry_q[idx_q*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, cin_q};
  assign deliver = (state_q == OUT) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    res_d   = res_q;
    idx_d   = idx_q;
    cin_d   = cin_q;
    cnt_d   = cnt_q;
    case (state_q)
      ACC: if (bus.in_valid) begin
        sum_d   = sum_q ^ carry_q ^ op;
        carry_d = {maj, 1'b0};
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        idx_d   = '0;
        cin_d   = 1'b0;
        if (bus.in_last) state_d = RES;
      end
      RES: begin
        res_d[idx_q*CHUNK +: CHUNK] = chunk[CHUNK-1:0];
        cin_d = chunk[CHUNK];
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(NCH-1)) state_d = OUT;
      end
      OUT: if (bus.out_ready) begin
        sum_d   = '0;
        carry_d = '0;
        cnt_d   = '0;
        state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      sum_q   <= '0;
      carry_q <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      cin_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      cin_q   <= cin_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef CSA_ACC_OVF_EN
  logic ovf_q, ovf_d;

  // op is 16 bits wide, so the top majority bit reduces to sum & carry.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == ACC && bus.in_valid && sum_q[ACC_W-1] && carry_q[ACC_W-1]) ovf_d = 1'b1;
    if (state_q == RES && idx_q == IDX_W'(NCH-1) && chunk[CHUNK]) ovf_d = 1'b1;
    if (deliver) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign bus.out_ovf = ovf_q;
`else
  assign bus.out_ovf = 1'b0;
`endif

  // Outputs decode registered state only; no path from in_valid/in_data.
  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_sum   = res_q;
  assign bus.out_count = cnt_q;
endmodule

// File: tb/tb_csa_accumulator.sv
// Directed self-checking bench for csa_accumulator (default ACC_W=20, CHUNK=4).
module tb_csa_accumulator;
  localparam int ACC_W = 20;
  localparam int CHUNK = 4;
  localparam int LAT   = ACC_W / CHUNK;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  csa_acc_if #(.ACC_W(ACC_W)) bus ();

  csa_accumulator #(.ACC_W(ACC_W), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Packet: beat i carries ops[min(i,2)]; n beats total, last flagged on beat n-1.
  typedef struct {
    logic [15:0]      op0, op1, op2;
    int               n;
    logic [ACC_W-1:0] exp_sum;
    logic [7:0]       exp_cnt;
    logic             exp_ovf_en;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge right after the accepting posedge.
  task automatic send_beat(input logic [15:0] d, input logic last);
    int k;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    k = 0;
    while (!bus.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("in_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] o0, o1, o2, input int n);
    for (int i = 0; i < n; i++)
      send_beat((i == 0) ? o0 : (i == 1) ? o1 : o2, i == n - 1);
  endtask

  // Returns cycles from last-accept edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int   lat;
    logic ovf_exp;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0] = '{16'd1,    16'd2,    16'd3,    3,   20'h00006, 8'd3,   1'b0};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1,   20'h0FFFF, 8'd1,   1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16,  20'hFFFF0, 8'd16,  1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 17,  20'h0FFEF, 8'd17,  1'b1};
    vecs[4] = '{16'hFFFF, 16'h0001, 16'h0001, 2,   20'h10000, 8'd2,   1'b0};
    vecs[5] = '{16'd1,    16'd1,    16'd1,    300, 20'h0012C, 8'd255, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 16'h0000, 1,   20'h00000, 8'd1,   1'b0};

    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_sum",   32'(bus.out_sum),   32'd0);
    chk("rst_out_count", 32'(bus.out_count), 32'd0);
    chk("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: out_ready held high, so it is also asserted while out_valid is low.
    bus.out_ready = 1'b1;
    foreach (vecs[v]) begin
      send_pkt(vecs[v].op0, vecs[v].op1, vecs[v].op2, vecs[v].n);
      chk($sformatf("v%0d_in_ready_res", v), 32'(bus.in_ready), 32'd0);
      wait_out(lat);
`ifdef CSA_ACC_OVF_EN
      ovf_exp = vecs[v].exp_ovf_en;
`else
      ovf_exp = 1'b0;
`endif
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'(LAT));
      chk($sformatf("v%0d_sum", v),     32'(bus.out_sum),   32'(vecs[v].exp_sum));
      chk($sformatf("v%0d_count", v),   32'(bus.out_count), 32'(vecs[v].exp_cnt));
      chk($sformatf("v%0d_ovf", v),     32'(bus.out_ovf),   32'(ovf_exp));
      @(negedge clk);
      chk($sformatf("v%0d_post_valid", v), 32'(bus.out_valid), 32'd0);
      chk($sformatf("v%0d_post_ready", v), 32'(bus.in_ready),  32'd1);
    end

    // Backpressure: result 6 held while operand 9 waits upstream.
    bus.out_ready = 1'b0;
    send_pkt(16'd1, 16'd2, 16'd3, 3);
    wait_out(lat);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd9;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_sum", i),   32'(bus.out_sum),   32'd6);
      chk($sformatf("hold%0d_count", i), 32'(bus.out_count), 32'd3);
      chk($sformatf("hold%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("hold%0d_ready", i), 32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("hold_accept_in_ready", 32'(bus.in_ready), 32'd1);
    send_beat(16'd9, 1'b1);
    wait_out(lat);
    chk("after_hold_latency", 32'(lat), 32'(LAT));
    chk("after_hold_sum",     32'(bus.out_sum),   32'd9);
    chk("after_hold_count",   32'(bus.out_count), 32'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset mid-resolve discards the packet.
    send_pkt(16'd5, 16'd7, 16'd7, 2);
    @(negedge clk);
    chk("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("mid_rst_count",     32'(bus.out_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_pkt(16'd4, 16'd4, 16'd4, 1);
    wait_out(lat);
    chk("post_rst_latency", 32'(lat), 32'(LAT));
    chk("post_rst_sum",     32'(bus.out_sum),   32'd4);
    chk("post_rst_count",   32'(bus.out_count), 32'd1);
    chk("post_rst_ovf",     32'(bus.out_ovf),   32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
